// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage and the ALU-control decoder.
// Holds the 4-bit control codes, the FSM state encoding and the flag bundle.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_ORR   = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_PASSB = 4'b0111;
    localparam logic [3:0] ALU_MUL   = 4'b1000;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } alu_flags_t;

endpackage

// File: rtl/alu_iter_mul.sv
// Iterative shift-add multiplier: one partial product per clock.
// Loaded by start; done is high during the last iteration, and product
// already includes that iteration, so the caller can capture it on that same edge.
module alu_iter_mul #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             done,
    output logic [WIDTH-1:0] product
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [CNT_W-1:0] cnt;
    logic             active;

    // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set.
    always_comb begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
    end

    assign done    = active & (cnt == CNT_W'(WIDTH - 1));
    assign product = acc_nxt;

    // Iteration registers: load on start, then shift one bit per cycle until done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b0;
        end else if (start) begin
            mcand  <= op_a;
            mplier <= op_b;
            acc    <= '0;
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            acc    <= acc_nxt;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (done) begin
                active <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered ALU execute stage with valid/ready on both sides and NZCV flags.
// Optional iterative multiply for code 1000 is built only when ALU_EXEC_MUL_EN is defined;
// otherwise that code is reported as illegal.
//
//  state | meaning
//  IDLE  | no result held, ready for input
//  BUSY  | iterative multiply in progress, input stalled
//  DONE  | result/flags held, out_valid high
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v,
    output logic             illegal
);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic             rdy_en;
    logic             xfer;
    logic             mul_go;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;

    logic             sub;
    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] eval_r;
    alu_flags_t       eval_f;
    logic             eval_ill;

    // rdy_en keeps in_ready low until the first edge after reset release.
    assign in_ready  = rdy_en & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign xfer      = in_valid & in_ready;
    assign out_valid = (state == ST_DONE);

`ifdef ALU_EXEC_MUL_EN
    assign mul_go = xfer & (alu_ctrl == ALU_MUL);

    alu_iter_mul #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (mul_go),
        .op_a    (op_a),
        .op_b    (op_b),
        .done    (mul_done),
        .product (mul_prod)
    );
`else
    assign mul_go   = 1'b0;
    assign mul_done = 1'b0;
    assign mul_prod = '0;
`endif

    // Single-cycle datapath; SUB reuses the adder as A + ~B + 1.
    always_comb begin
        sub      = (alu_ctrl == ALU_SUB);
        addend   = sub ? ~op_b : op_b;
        sum      = {1'b0, op_a} + {1'b0, addend} + {{WIDTH{1'b0}}, sub};
        eval_r   = '0;
        eval_f   = '0;
        eval_ill = 1'b0;
        case (alu_ctrl)
            ALU_AND:   eval_r = op_a & op_b;
            ALU_ORR:   eval_r = op_a | op_b;
            ALU_ADD,
            ALU_SUB: begin
                eval_r   = sum[WIDTH-1:0];
                eval_f.c = sum[WIDTH];
                eval_f.v = (op_a[WIDTH-1] == addend[WIDTH-1]) & (sum[WIDTH-1] != op_a[WIDTH-1]);
            end
            ALU_PASSB: eval_r = op_b;
            default:   eval_ill = 1'b1;
        endcase
        // Illegal codes report all flags clear, including Z.
        if (!eval_ill) begin
            eval_f.n = eval_r[WIDTH-1];
            eval_f.z = (eval_r == '0);
        end
    end

    // Next-state logic for the IDLE/BUSY/DONE handshake FSM.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (xfer) state_nxt = mul_go ? ST_BUSY : ST_DONE;
            ST_BUSY: if (mul_done) state_nxt = ST_DONE;
            ST_DONE: if (out_ready) state_nxt = xfer ? (mul_go ? ST_BUSY : ST_DONE) : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State register plus the post-reset ready enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rdy_en <= 1'b0;
        end else begin
            state  <= state_nxt;
            rdy_en <= 1'b1;
        end
    end

    // Output registers: load on a single-cycle transfer or multiply completion, otherwise hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result  <= '0;
            flag_n  <= 1'b0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
        end else if (xfer && !mul_go) begin
            result  <= eval_r;
            flag_n  <= eval_f.n;
            flag_z  <= eval_f.z;
            flag_c  <= eval_f.c;
            flag_v  <= eval_f.v;
            illegal <= eval_ill;
        end else if ((state == ST_BUSY) && mul_done) begin
            result  <= mul_prod;
            flag_n  <= mul_prod[WIDTH-1];
            flag_z  <= (mul_prod == '0);
            flag_c  <= 1'b0;
            flag_v  <= 1'b0;
            illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit. Multiply checks follow ALU_EXEC_MUL_EN.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int W = 64;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [3:0]   alu_ctrl;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         flag_n, flag_z, flag_c, flag_v, illegal;

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_ctrl  (alu_ctrl),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .flag_n    (flag_n),
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .illegal   (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [W-1:0] r;
        logic [4:0]   f;   // n z c v illegal
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_pop = 0;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic exp_t model(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t       e;
        logic [W:0] s;
        logic       cf, vf, ill;
        e   = '0;
        cf  = 1'b0;
        vf  = 1'b0;
        ill = 1'b0;
        case (c)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b0010: begin
                s    = {1'b0, a} + {1'b0, b};
                e.r  = s[W-1:0];
                cf   = s[W];
                s    = {a[W-1], a} + {b[W-1], b};
                vf   = (s[W] != s[W-1]);
            end
            4'b0110: begin
                e.r  = a - b;
                cf   = (a >= b);
                s    = {a[W-1], a} - {b[W-1], b};
                vf   = (s[W] != s[W-1]);
            end
            4'b0111: e.r = b;
`ifdef ALU_EXEC_MUL_EN
            4'b1000: e.r = a * b;
`endif
            default: ill = 1'b1;
        endcase
        if (ill) e.f = 5'b00001;
        else     e.f = {e.r[W-1], (e.r == '0), cf, vf, 1'b0};
        return e;
    endfunction

    // Output monitor: sample just before the edge, pop and compare on each output handshake.
    always begin
        @(negedge clk);
        #3;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", out_valid, 1'b0);
            end else begin
                mon_e = sb.pop_front();
                chk("sb_result", result, mon_e.r);
                chk("sb_flags", {flag_n, flag_z, flag_c, flag_v, illegal}, mon_e.f);
                n_pop++;
            end
        end
    end

    // Drive one operation from negedge+1; returns at negedge+1 after it is accepted.
    task automatic send(input logic [3:0] c, input logic [W-1:0] a, input logic [W-1:0] b);
        int t = 0;
        bit done = 0;
        in_valid = 1'b1;
        alu_ctrl = c;
        op_a     = a;
        op_b     = b;
        while (!done) begin
            #2;
            if (in_ready) begin
                sb.push_back(model(c, a, b));
                done = 1;
            end
            @(negedge clk);
            #1;
            if (!done) begin
                t++;
                if (t > 300) begin
                    chk("send_in_ready", in_ready, 1'b1);
                    done = 1;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    logic [3:0] codes [6];
    exp_t       e1;
    int         c0, p0;
    bit         seen;

    initial begin
        codes = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b0101};
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_ctrl  = 4'b0;
        op_a      = '0;
        op_b      = '0;
        idle(2);

        // Reset values and in_ready release timing
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_result", result, '0);
        chk("rst_flags", {flag_n, flag_z, flag_c, flag_v, illegal}, 5'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        rst_n = 1'b1;
        #2;
        chk("rdy_before_edge", in_ready, 1'b0);
        idle(1);
        chk("rdy_after_edge", in_ready, 1'b1);

        // ADD boundaries
        send(ALU_ADD, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1);
        send(ALU_ADD, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        // SUB / PASS_B boundaries
        send(ALU_SUB, 64'd5, 64'd7);
        send(ALU_SUB, 64'd7, 64'd7);
        send(ALU_PASSB, 64'h1234, 64'd0);
        send(ALU_AND, 64'hF0F0_0000_FFFF_0F0F, 64'hFF00_FF00_0F0F_00FF);
        send(ALU_ORR, 64'h8000_0000_0000_0000, 64'h1);
        send(ALU_SUB, 64'h8000_0000_0000_0000, 64'd1);
        idle(2);

        // Illegal code: one-cycle latency, illegal flag set
        send(4'b0101, 64'd3, 64'd4);
        #2;
        chk("illegal_latency", {out_valid, illegal, result}, {2'b11, 64'd0});
        idle(1);
`ifndef ALU_EXEC_MUL_EN
        send(ALU_MUL, 64'd12, 64'd13);
        #2;
        chk("mul_illegal_latency", {out_valid, illegal, result}, {2'b11, 64'd0});
        idle(1);
`endif
        idle(2);

        // Backpressure: hold first result for 4 cycles, then drain in order at one per cycle
        out_ready = 1'b0;
        e1 = model(ALU_ADD, 64'd10, 64'd20);
        send(ALU_ADD, 64'd10, 64'd20);
        in_valid = 1'b1;
        alu_ctrl = ALU_SUB;
        op_a     = 64'd100;
        op_b     = 64'd1;
        for (int i = 0; i < 4; i++) begin
            #2;
            chk("bp_hold_result", {out_valid, result}, {1'b1, e1.r});
            chk("bp_in_ready", in_ready, 1'b0);
            idle(1);
        end
        out_ready = 1'b1;
        c0 = cyc;
        p0 = n_pop;
        send(ALU_SUB, 64'd100, 64'd1);
        send(ALU_ORR, 64'h00F0, 64'h0F00);
        idle(1);
        chk("bp_drain_count", n_pop - p0, 3);
        chk("bp_drain_cycles", cyc - c0, 3);

        // Randomised single-cycle traffic with gaps
        for (int i = 0; i < 24; i++) begin
            send(codes[$urandom_range(0, 5)], {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 2) == 0) idle(1);
        end
        idle(3);

        // Reset mid-traffic while a result is held
        out_ready = 1'b0;
        send(ALU_ADD, 64'd1, 64'd2);
        rst_n = 1'b0;
        sb.delete();
        #2;
        chk("rst_mid_out_valid", out_valid, 1'b0);
        chk("rst_mid_result", result, '0);
        chk("rst_mid_flags", {flag_n, flag_z, flag_c, flag_v, illegal}, 5'b0);
        idle(1);
        rst_n = 1'b1;
        out_ready = 1'b1;
        #2;
        chk("rst_mid_rdy_before_edge", in_ready, 1'b0);
        idle(1);
        chk("rst_mid_rdy_after_edge", in_ready, 1'b1);

`ifdef ALU_EXEC_MUL_EN
        // Multiply: WIDTH busy cycles with input stalled, then result
        send(ALU_MUL, 64'd12, 64'd13);
        for (int i = 0; i < W; i++) begin
            #2;
            chk("mul_busy", {in_ready, out_valid}, 2'b00);
            idle(1);
        end
        #2;
        chk("mul_done_latency", out_valid, 1'b1);
        idle(2);
        send(ALU_MUL, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3);
        idle(W + 3);
        send(ALU_ADD, 64'd4, 64'd5);
        idle(2);

        // Reset during BUSY aborts the multiply
        send(ALU_MUL, 64'd5, 64'd7);
        idle(10);
        rst_n = 1'b0;
        sb.delete();
        idle(1);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (W + 5) begin
            #2;
            if (out_valid) seen = 1'b1;
            idle(1);
        end
        chk("mul_abort_no_output", seen, 1'b0);
`endif

        idle(3);
        chk("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
